// File: rtl/bcd_chain_counter_pkg.sv
// Shared types and helpers for the BCD digit chain counter.
// Used by both the top level (bcd_chain_counter) and its per-digit cell.
package bcd_chain_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   // Saturate a digit against a limit.
   function automatic bcd_digit_t bcd_clamp(bcd_digit_t v, bcd_digit_t lim);
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/bcd_chain_counter_if.sv
// Control and data bundle for one BCD chain counter.
// master drives the controls; slave is the counter side.
interface bcd_chain_counter_if #(parameter int DIGITS = 4);

   logic                  carry_in;
   logic                  down;
   logic                  clear;
   logic                  load;
   logic [DIGITS*4-1:0]   load_value;
   logic [DIGITS*4-1:0]   limit;
   logic [DIGITS*4-1:0]   value;
   logic                  carry_out;
   logic                  is_zero;

   modport master (
      output carry_in, down, clear, load, load_value, limit,
      input  value, carry_out, is_zero
   );

   modport slave (
      input  carry_in, down, clear, load, load_value, limit,
      output value, carry_out, is_zero
   );

endinterface

// File: rtl/bcd_chain_counter_digit_cell.sv
// One BCD digit register with wrap/borrow terminal detection.
// Down counting is only built when BCD_CHAIN_DOWN_EN is defined.
module bcd_digit_cell
   import bcd_chain_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       step,
   input  logic       down,
   input  logic       clear,
   input  logic       load,
   input  bcd_digit_t load_digit,
   input  bcd_digit_t lim,
   output bcd_digit_t value,
   output logic       terminal
);

   bcd_digit_t value_nxt;

`ifdef BCD_CHAIN_DOWN_EN
   // An out-of-range digit is non-zero, so it never borrows when counting down.
   assign terminal = down ? (value == 4'd0) : (value >= lim);
`else
   logic unused_down;
   assign unused_down = down;
   assign terminal    = (value >= lim);
`endif

   always_comb begin
      value_nxt = value;
      if (clear) begin
         value_nxt = '0;
      end else if (load) begin
         value_nxt = bcd_clamp(load_digit, lim);
      end else if (step) begin
`ifdef BCD_CHAIN_DOWN_EN
         if (down) begin
            value_nxt = (terminal || (value > lim)) ? lim : value - 4'd1;
         end else begin
            value_nxt = terminal ? 4'd0 : value + 4'd1;
         end
`else
         value_nxt = terminal ? 4'd0 : value + 4'd1;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         value <= '0;
      end else begin
         value <= value_nxt;
      end
   end

endmodule

// File: rtl/bcd_chain_counter.sv
// Chain of DIGITS BCD digits with runtime per-digit limits, single-cycle ripple carry.
// Define BCD_CHAIN_DOWN_EN to build the down/borrow path.
module bcd_chain_counter
   import bcd_chain_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   bcd_chain_counter_if.slave bus
);

   logic [DIGITS:0]   step;
   logic [DIGITS-1:0] terminal;
   bcd_digit_t        lim       [DIGITS];
   bcd_digit_t        digit_val [DIGITS];

   // clear/load pre-empt counting, which also keeps carry_out low in that cycle.
   assign step[0] = bus.carry_in & ~bus.clear & ~bus.load;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign lim[i] = bcd_clamp(bus.limit[4*i +: 4], BCD_MAX);

      bcd_digit_cell u_cell (
         .clk        (clk),
         .reset_n    (reset_n),
         .step       (step[i]),
         .down       (bus.down),
         .clear      (bus.clear),
         .load       (bus.load),
         .load_digit (bus.load_value[4*i +: 4]),
         .lim        (lim[i]),
         .value      (digit_val[i]),
         .terminal   (terminal[i])
      );

      assign step[i+1]            = step[i] & terminal[i];
      assign bus.value[4*i +: 4]  = digit_val[i];
   end

   assign bus.carry_out = reset_n & step[DIGITS];
   assign bus.is_zero   = ~|bus.value;

endmodule

// File: tb/tb_bcd_chain_counter.sv
// Directed plus model-checked stimulus for bcd_chain_counter (DIGITS=4).
// Down-count checks are compiled in only when BCD_CHAIN_DOWN_EN is defined.
module tb_bcd_chain_counter;

   logic clk;
   logic reset_n;
   int   n_vec = 0;
   int   n_err = 0;
   logic [15:0] exp_q [$];

   bcd_chain_counter_if #(.DIGITS(4)) bus ();

   bcd_chain_counter #(.DIGITS(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle, check carry_out mid-cycle, then value/is_zero after the edge.
   task automatic do_step(input string tag, input logic ci, input logic clr, input logic ld,
                          input logic [15:0] lv, input logic exp_co, input logic [15:0] exp_val);
      logic [15:0] e;
      @(negedge clk);
      bus.carry_in   = ci;
      bus.clear      = clr;
      bus.load       = ld;
      bus.load_value = lv;
      exp_q.push_back(exp_val);
      #1;
      check({tag, ".co"}, {15'd0, bus.carry_out}, {15'd0, exp_co});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({tag, ".val"}, bus.value, e);
      check({tag, ".zero"}, {15'd0, bus.is_zero}, {15'd0, (e == 16'h0)});
      bus.carry_in = 1'b0;
      bus.clear    = 1'b0;
      bus.load     = 1'b0;
   endtask

   // Up-count reference: returns {carry_out, next value}.
   function automatic logic [16:0] model_up(input logic [15:0] v, input logic [15:0] limv, input logic ci);
      logic [15:0] nv;
      logic        s;
      int          d, l;
      nv = v;
      s  = ci;
      for (int i = 0; i < 4; i++) begin
         d = int'(v[4*i +: 4]);
         l = int'(limv[4*i +: 4]);
         if (l > 9) l = 9;
         if (s) begin
            if (d >= l) nv[4*i +: 4] = 4'd0;
            else        nv[4*i +: 4] = 4'(d + 1);
            s = (d >= l);
         end
      end
      return {s, nv};
   endfunction

   initial begin
      logic [15:0] mv;
      logic [16:0] r;
      logic        ci;
      logic [3:0]  seq [8];

      reset_n        = 1'b0;
      bus.carry_in   = 1'b1;
      bus.down       = 1'b0;
      bus.clear      = 1'b0;
      bus.load       = 1'b0;
      bus.load_value = 16'h0;
      bus.limit      = 16'h0000;
      #1;
      check("rst.val", bus.value, 16'h0);
      check("rst.zero", {15'd0, bus.is_zero}, 16'h1);
      check("rst.co", {15'd0, bus.carry_out}, 16'h0);
      @(negedge clk);
      bus.carry_in = 1'b0;
      reset_n      = 1'b1;

      // Rollover 59 -> 00 with carry
      bus.limit = 16'h0059;
      do_step("load59", 1'b0, 1'b0, 1'b1, 16'h0059, 1'b0, 16'h0059);
      do_step("roll", 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0000);

      // Load clamp and priority
      do_step("clamp", 1'b0, 1'b0, 1'b1, 16'h007A, 1'b0, 16'h0059);
      do_step("prio", 1'b1, 1'b1, 1'b1, 16'h0033, 1'b0, 16'h0000);
      do_step("ldci", 1'b1, 1'b0, 1'b1, 16'h0042, 1'b0, 16'h0042);

      // 0..3 digit
      bus.limit = 16'h0003;
      do_step("clr03", 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
      seq = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
      for (int i = 0; i < 8; i++) begin
         do_step($sformatf("mod4_%0d", i), 1'b1, 1'b0, 1'b0, 16'h0,
                 (i == 3 || i == 7), {12'h0, seq[i]});
      end

      // Out-of-range digit after limit is lowered
      bus.limit = 16'h0009;
      do_step("ld7", 1'b0, 1'b0, 1'b1, 16'h0007, 1'b0, 16'h0007);
      bus.limit = 16'h0003;
      do_step("oor_up", 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0000);

      // Multi-digit ripple and async reset mid-count
      bus.limit = 16'h9999;
      do_step("ld123", 1'b0, 1'b0, 1'b1, 16'h0123, 1'b0, 16'h0123);
      do_step("inc124", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0124);
      @(negedge clk);
      bus.carry_in = 1'b1;
      reset_n      = 1'b0;
      #1;
      check("arst.val", bus.value, 16'h0);
      check("arst.co", {15'd0, bus.carry_out}, 16'h0);
      @(posedge clk);
      #1;
      check("arst.hold", bus.value, 16'h0);
      @(negedge clk);
      reset_n      = 1'b1;
      bus.carry_in = 1'b0;
      do_step("post_rst", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0001);
      do_step("ld999", 1'b0, 1'b0, 1'b1, 16'h0999, 1'b0, 16'h0999);
      do_step("rip1000", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h1000);
      do_step("ld9999", 1'b0, 1'b0, 1'b1, 16'h9999, 1'b0, 16'h9999);
      do_step("wrap4", 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0000);
      do_step("hold", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0000);

      // Random limits (including >9 and 0) against the reference model
      mv = 16'h0;
      for (int i = 0; i < 40; i++) begin
         if (i % 10 == 0) bus.limit = 16'($urandom());
         ci = 1'($urandom_range(0, 3) != 0);
         r  = model_up(mv, bus.limit, ci);
         do_step($sformatf("rnd%0d", i), ci, 1'b0, 1'b0, 16'h0, r[16], r[15:0]);
         mv = r[15:0];
      end

`ifdef BCD_CHAIN_DOWN_EN
      bus.limit = 16'h0059;
      do_step("dclr", 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0000);
      bus.down = 1'b1;
      do_step("borrow", 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0059);
      do_step("dn58", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0058);
      do_step("dn57", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0057);
      do_step("dn56", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0056);
      do_step("dn50", 1'b0, 1'b0, 1'b1, 16'h0050, 1'b0, 16'h0050);
      do_step("dn49", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0049);
      bus.limit = 16'h0009;
      do_step("dld7", 1'b0, 1'b0, 1'b1, 16'h0007, 1'b0, 16'h0007);
      bus.limit = 16'h0003;
      do_step("oor_dn", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0003);
      bus.down = 1'b0;
      do_step("dir_up", 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0000);
`else
      bus.limit = 16'h9999;
      do_step("uclr", 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0000);
      bus.down = 1'b1;
      do_step("uponly", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0001);
      bus.down = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bcd_chain_counter.md
# bcd_chain_counter

Parametrised chain of BCD digit counters with a runtime modulus for each digit, up/down direction, synchronous clear, and parallel load. Each step ripples carries or borrows through all digits in one cycle. The block replaces hand-cascaded single-digit 0–9/0–3 counters in clock, timer and display datapaths, for example HH:MM:SS and stopwatch counters. One `carry_out` feeds the next chain, and `carry_in` accepts the previous chain's carry.

## Interface
- `DIGITS`, default 4: number of BCD digits. Legal range is 1..8. Digit 0 is least significant.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `carry_in` input, 1 bit: count enable, one step per cycle while high.
- `down` input, 1 bit: 0 counts up, 1 counts down. Only honoured when `BCD_CHAIN_DOWN_EN` is defined.
- `clear` input, 1 bit: synchronous clear of all digits to 0.
- `load` input, 1 bit: synchronous parallel load.
- `load_value` input, DIGITS*4 bits: load data. Digit i is at [4i+3:4i].
- `limit` input, DIGITS*4 bits: per-digit maximum value, giving a modulus of limit+1. Digit i is at [4i+3:4i].
- `value` output, DIGITS*4 bits: registered count.
- `carry_out` output, 1 bit: combinational wrap (up) or borrow (down) of the whole chain.
- `is_zero` output, 1 bit: combinational, high when every digit is 0.

## Operation
- Effective limit per digit: `lim_i = min(limit_i, 9)`.
  - `limit_i = 0` gives a digit that is constantly 0 and always terminal.
- Priority, highest first: `reset_n` low, then `clear`, then `load`, then counting.
- **Clear:** all digits become 0, and `carry_out` is 0 that cycle.
- **Load:** digit i is set to `min(load_value_i, lim_i)`. `carry_in` is ignored and `carry_out` is 0 that cycle.
- **Counting up:**
  - Digit i is terminal when `value_i >= lim_i`.
  - `step_0 = carry_in`, and `step_{i+1} = step_i & terminal_i`.
  - A stepping digit that is terminal becomes 0. Otherwise it increments by 1.
  - `carry_out = step_{DIGITS-1} & terminal_{DIGITS-1}`.
- **Counting down:**
  - Digit i is terminal when `value_i == 0`.
  - A stepping digit that is terminal becomes `lim_i`. Otherwise it decrements by 1.
  - `carry_out` (the borrow) uses the same chain expression as counting up.
- **Out-of-range digit** (`value_i > lim_i`, possible after `limit` changes at runtime):
  - Counting up: it is terminal, wraps to 0 and propagates a carry.
  - Counting down: it loads `lim_i` and does not propagate a borrow.
- Digits whose step is 0 hold their value.
- `limit` may change on any cycle and takes effect on the next evaluation. Existing digit values are never clamped except by the stepping rules above.
- `is_zero` is decoded directly from `value`.

## Timing
- `reset_n` low: `value` goes to 0 immediately. `carry_out` is forced to 0 and `is_zero` is 1 while reset is held.
- After reset, the first rising edge with `reset_n` high may act on the inputs. There is no extra recovery cycle beyond normal recovery/removal timing.
- **Counting latency:** a step requested in cycle n is visible on `value` after the edge ending cycle n.
- **`carry_out` timing:** combinational, valid in the same cycle as the `carry_in` that causes the wrap. Downstream chains register it on the same edge.
- The full carry chain settles within one clock. There is no pipelining, so the critical path is DIGITS compare/AND stages.
- **Reset mid-count:** the count is lost and no `carry_out` pulse is produced.
- **`clear` or `load` with `carry_in` in the same cycle:** `clear`/`load` wins and no step occurs.
- **`down` toggled between cycles:** takes effect immediately. There is no state tied to direction.

## Configuration
- `BCD_CHAIN_DOWN_EN` defined: `down` selects direction and borrow logic is built.
- Not defined:
  - The `down` port still exists but is ignored.
  - The block counts up only.
  - Borrow and down-step logic are not synthesised.

## Structure
- Package `bcd_chain_pkg`:
  - `typedef logic [3:0] bcd_digit_t`.
  - `localparam bcd_digit_t BCD_MAX = 4'd9`.
  - Function `bcd_clamp(bcd_digit_t v, bcd_digit_t lim)` returning the saturated limit.
- Sub-module `bcd_digit_cell`, instantiated DIGITS times in a generate loop:
  - Holds one digit register.
  - Inputs: `step`, `down`, `clear`, `load`, `load_digit`, `lim`.
  - Outputs: `value`, `terminal`.
- The top level forms the step chain, `carry_out` and `is_zero`.

## Test plan
- **Rollover up.** DIGITS=2, limit={5,9}, load 59, then `carry_in`=1 for 1 cycle. Expect `carry_out`=1 in that cycle, then value=00 and `is_zero`=1.
- **Borrow down** (`BCD_CHAIN_DOWN_EN`). limit={5,9}, value 00, `down`=1, `carry_in`=1. Expect `carry_out`=1, then value=59. Three more steps give 56.
- **0–3 digit.** DIGITS=1, limit=3, count up from 0 for 8 cycles. Expect the sequence 1,2,3,0,1,2,3,0, with `carry_out` high on cycles 4 and 8 only.
- **Load clamp and priority.**
  - `load_value`=0x7A with limit={5,9} gives value 0x59.
  - `clear`+`load`+`carry_in` together gives value 0.
  - Out-of-range: limit lowered to 3 while the digit=7, then one up step gives 0 with a carry.
- **Async reset mid-count.** Count 0123 → 0124, then drop `reset_n` between edges. Expect value=0 before the next edge and `carry_out`=0 while low. Release, then one step gives 0001.
- **Up-only build** (macro undefined). `down`=1 with `carry_in`=1 from 0000 gives 0001.
